decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder for SEL_W-bit indices and 2**SEL_W outputs. It generalises the 2-to-4 decoder with two modes: direct decode of an input index, and an auto-scan sequencer that steps the active output at a programmable dwell period. It drives multiplexed loads such as digit enables or LED columns, and reports the active index and a wrap pulse for downstream data muxing.

---
 rtl/decoder_pkg.sv | 14 +
 rtl/onehot_dec.sv | 15 +
 rtl/decoder_scan.sv | 92 +++++++++
 tb/tb_decoder_scan.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_scan shared types: FSM state encoding and mode constants.
// Imported by the decoder_scan top and its one-hot sub-module.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index to one-hot decoder, 2**SEL_W outputs.
// Ports: sel_i index in, onehot_o one-hot vector out.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(1<<SEL_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT decode and timed auto-scan.
// Ports: clk, rst_n, en, mode, num, dwell in; decoder_out, cur_sel, wrap out.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 2,
  parameter  int DWELL_W = 16,
  localparam int NUM_OUT = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   num,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NUM_OUT-1:0] decoder_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap
);

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [NUM_OUT-1:0]   dec_q, dec_d;
  logic                 wrap_q, wrap_d;
  logic [NUM_OUT-1:0]   oh;

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i    (sel_d),
    .onehot_o (oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      dec_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      dec_q   <= dec_d;
      wrap_q  <= wrap_d;
    end
  end

  // Same transition rule from every state: en gates, mode picks.
  always_comb begin
    state_d = IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
    end
  end

  always_comb begin
    cnt_d  = '0;
    sel_d  = sel_q;
    wrap_d = 1'b0;
    unique case (state_d)
      IDLE: begin
        sel_d = sel_q;
      end
      DIRECT: begin
        sel_d = num;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          sel_d = '0;
        end else if (cnt_q >= dwell) begin
          // >= so a lowered dwell steps at once
          sel_d  = sel_q + 1'b1;
          wrap_d = &sel_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase
    dec_d = (state_d == IDLE) ? '0 : oh;
  end

  assign decoder_out = dec_q;
  assign cur_sel     = sel_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan, SEL_W=2 and SEL_W=3 instances.
// Expected outputs are queued per step and compared after each edge.
module tb_decoder_scan;

  typedef struct {
    string      tag;
    bit         big;
    logic [7:0] dec;
    logic [2:0] sel;
    logic       wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, mode;
  logic [1:0]  num2;
  logic [2:0]  num3;
  logic [15:0] dwell;
  logic [3:0]  dec2;
  logic [1:0]  sel2;
  logic        wrap2;
  logic [7:0]  dec3;
  logic [2:0]  sel3;
  logic        wrap3;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DWELL_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .num(num2), .dwell(dwell), .decoder_out(dec2),
    .cur_sel(sel2), .wrap(wrap2)
  );

  decoder_scan #(.SEL_W(3), .DWELL_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .num(num3), .dwell(dwell), .decoder_out(dec3),
    .cur_sel(sel3), .wrap(wrap3)
  );

  task automatic push(input string tag, input bit big,
                      input logic [7:0] d, input logic [2:0] s,
                      input logic w);
    exp_t e;
    e.tag = tag; e.big = big;
    e.dec = d; e.sel = s; e.wrap = w;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] od;
    logic [2:0] os;
    logic       ow;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      od = e.big ? dec3 : {4'b0, dec2};
      os = e.big ? sel3 : {1'b0, sel2};
      ow = e.big ? wrap3 : wrap2;
      checks++;
      assert ({od, os, ow} === {e.dec, e.sel, e.wrap})
      else begin
        errors++;
        $error("FAIL %s dec/sel/wrap got %h/%0d/%b exp %h/%0d/%b",
               e.tag, od, os, ow, e.dec, e.sel, e.wrap);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0;
    num2 = '0; num3 = '0; dwell = '0;
    #3;
    push("rst2", 0, 8'h00, 3'd0, 1'b0);
    push("rst3", 1, 8'h00, 3'd0, 1'b0);
    drain();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      push("idle", 0, 8'h00, 3'd0, 1'b0);
      step();
    end

    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      num2 = 2'(i);
      push("direct", 0, 8'(1) << i, 3'(i), 1'b0);
      step();
    end

    mode = 1'b1; dwell = 16'd2;
    for (int k = 0; k < 28; k++) begin
      idx = (k / 3) % 8;
      push("scan_d2", 1, 8'(1) << idx, 3'(idx),
           (k == 24) ? 1'b1 : 1'b0);
      step();
    end

    en = 1'b0;
    push("off_a", 1, 8'h00, 3'd1, 1'b0);
    step();
    en = 1'b1; dwell = 16'd0;
    for (int k = 0; k < 10; k++) begin
      idx = k % 8;
      push("scan_d0", 1, 8'(1) << idx, 3'(idx),
           (k == 8) ? 1'b1 : 1'b0);
      step();
    end

    en = 1'b0;
    push("off_b", 1, 8'h00, 3'd1, 1'b0);
    step();
    en = 1'b1; dwell = 16'd5;
    for (int k = 0; k < 5; k++) begin
      push("scan_d5", 1, 8'h01, 3'd0, 1'b0);
      step();
    end
    dwell = 16'd1;
    for (int k = 0; k < 6; k++) begin
      idx = 1 + k / 2;
      push("scan_d1", 1, 8'(1) << idx, 3'(idx), 1'b0);
      step();
    end

    en = 1'b0;
    step();
    en = 1'b1; mode = 1'b1; dwell = 16'd0;
    for (int k = 0; k < 3; k++) begin
      push("to_idx2", 0, 8'(1) << k, 3'(k), 1'b0);
      step();
    end
    mode = 1'b0; num2 = 2'd1;
    push("sw_direct", 0, 8'h02, 3'd1, 1'b0);
    step();
    en = 1'b0;
    push("sw_off", 0, 8'h00, 3'd1, 1'b0);
    step();
    en = 1'b1; mode = 1'b1; dwell = 16'd3;
    push("sw_scan", 0, 8'h01, 3'd0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      idx = (k == 3) ? 1 : 0;
      push("scan_d3", 0, 8'(1) << idx, 3'(idx), 1'b0);
      step();
    end

    #2 rst_n = 1'b0;
    #1;
    push("arst2", 0, 8'h00, 3'd0, 1'b0);
    push("arst3", 1, 8'h00, 3'd0, 1'b0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    push("resume", 0, 8'h01, 3'd0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      idx = (k == 3) ? 1 : 0;
      push("resume_d3", 0, 8'(1) << idx, 3'(idx), 1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
